// File: rtl/mole_display.sv
// Single-hole whack-a-mole display controller: lights one LED per mole, times it, reports hit/miss.
// Optional blinking of the lit mole is enabled by defining MOLE_BLINK_EN.
module mole_display #(
    parameter int NUM_HOLES   = 18,
    parameter int SHOW_CYCLES = 50000000,
    parameter int BLINK_DIV   = 6250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  number,
    input  logic [17:0] whack,
    output logic [17:0] displayL,
    output logic        hit,
    output logic        miss
);

    localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [4:0] NO_MOLE = 5'd31;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    if (NUM_HOLES != 18 || SHOW_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("mole_display: unsupported parameter values");
    end

    logic [0:0]    state, state_nx;
    logic [4:0]    pos, pos_nx;
    logic [4:0]    last, last_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          hit_nx, miss_nx;
    logic          valid_num;
    logic          whack_pos;
    logic [17:0]   pos_image;
    logic [17:0]   blink_mask;

    assign valid_num = (number < 5'(NUM_HOLES));
    assign whack_pos = |(whack & (18'(1) << pos));
    assign pos_image = 18'(1) << pos_nx;

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        last_nx  = last;
        timer_nx = timer;
        hit_nx   = 1'b0;
        miss_nx  = 1'b0;
        case (state)
            IDLE: begin
                // The same index does not re-pop until number changes or goes invalid.
                if (valid_num && (number != last)) begin
                    pos_nx   = number;
                    last_nx  = number;
                    timer_nx = TIMER_LOAD;
                    state_nx = SHOW;
                end else if (!valid_num) begin
                    last_nx = NO_MOLE;
                end
            end
            SHOW: begin
                if (whack_pos) begin
                    hit_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (!valid_num) begin
                    last_nx  = NO_MOLE;
                    state_nx = IDLE;
                end else if (number != pos) begin
                    pos_nx   = number;
                    last_nx  = number;
                    timer_nx = TIMER_LOAD;
                end else if (timer == '0) begin
                    miss_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef MOLE_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          blink, blink_nx;
    logic          enter_show;

    assign enter_show = (state == IDLE) && (state_nx == SHOW);

    // Restarting on entry makes every new mole begin with a full lit half-period.
    always_comb begin
        blink_cnt_nx = blink_cnt;
        blink_nx     = blink;
        if (enter_show) begin
            blink_cnt_nx = '0;
            blink_nx     = 1'b1;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt_nx = '0;
            blink_nx     = ~blink;
        end else begin
            blink_cnt_nx = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_nx;
            blink     <= blink_nx;
        end
    end

    assign blink_mask = {18{blink_nx}};
`else
    assign blink_mask = '1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            last     <= NO_MOLE;
            timer    <= '0;
            displayL <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            state    <= state_nx;
            pos      <= pos_nx;
            last     <= last_nx;
            timer    <= timer_nx;
            displayL <= (state_nx == SHOW) ? (pos_image & blink_mask) : '0;
            hit      <= hit_nx;
            miss     <= miss_nx;
        end
    end

endmodule

// File: tb/tb_mole_display.sv
// Bench for mole_display: directed vector table, hand-written corner sequences, random run vs model.
module tb_mole_display;

    localparam int SHOW = 10;
    localparam int BDIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  number = 5'd31;
    logic [17:0] whack = '0;
    logic [17:0] displayL;
    logic        hit;
    logic        miss;

    int n_checks = 0;
    int n_fail = 0;

    mole_display #(
        .NUM_HOLES(18),
        .SHOW_CYCLES(SHOW),
        .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .number(number),
        .whack(whack),
        .displayL(displayL),
        .hit(hit),
        .miss(miss)
    );

    always #5 clk = ~clk;

    // Reference model: one mole with an age in lit cycles.
    bit   m_active;
    int   m_hole;
    int   m_last;
    int   m_age;
    int   m_bage;
    logic [19:0] exp_q[$];

    typedef struct {
        logic [4:0]  num;
        logic [17:0] wh;
        logic [17:0] disp;
        logic        h;
        logic        m;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_hole = 0;
        m_last = 31;
        m_age = 0;
        m_bage = 0;
        exp_q.delete();
    endfunction

    function automatic logic [17:0] model_image();
        logic [17:0] img;
        img = m_active ? (18'd1 << m_hole) : 18'd0;
`ifdef MOLE_BLINK_EN
        if (((m_bage / BDIV) % 2) != 0) img = 18'd0;
`endif
        return img;
    endfunction

    function automatic void model_step(input int n, input logic [17:0] w);
        logic h = 1'b0;
        logic m = 1'b0;
        bit valid = (n < 18);
        if (!m_active) begin
            if (valid && n != m_last) begin
                m_active = 1'b1;
                m_hole = n;
                m_last = n;
                m_age = 0;
                m_bage = 0;
            end else if (!valid) begin
                m_last = 31;
            end
        end else begin
            m_bage++;
            if (w[m_hole]) begin
                h = 1'b1;
                m_active = 1'b0;
            end else if (!valid) begin
                m_active = 1'b0;
                m_last = 31;
            end else if (n != m_hole) begin
                m_hole = n;
                m_last = n;
                m_age = 0;
            end else if (m_age == SHOW - 1) begin
                m = 1'b1;
                m_active = 1'b0;
            end else begin
                m_age++;
            end
        end
        exp_q.push_back({model_image(), h, m});
    endfunction

    task automatic step(input logic [4:0] n, input logic [17:0] w, input string name);
        logic [19:0] e;
        number = n;
        whack = w;
        @(posedge clk);
        model_step(int'(n), w);
        #1;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 20'd1, 20'd0);
        end else begin
            e = exp_q.pop_front();
            check(name, {displayL, hit, miss}, e);
        end
        check({name, "_exclusive"}, {19'd0, hit & miss}, 20'd0);
    endtask

    task automatic table_step(input vec_t v, input string name);
        logic [19:0] discard;
        number = v.num;
        whack = v.wh;
        @(posedge clk);
        model_step(int'(v.num), v.wh);
        discard = exp_q.pop_front();
        #1;
        check(name, {displayL, hit, miss}, {v.disp, v.h, v.m});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        number = 5'd31;
        whack = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {displayL, hit, miss}, 20'd0);
        reset = 1'b0;
    endtask

    function automatic void add(input logic [4:0] n, input logic [17:0] w,
                                input logic [17:0] d, input logic h, input logic m);
        vec_t v;
        v.num = n;
        v.wh = w;
        v.disp = d;
        v.h = h;
        v.m = m;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [4:0]  cur_n;
        logic [17:0] w;
        int          miss_seen;

        do_reset();

`ifdef MOLE_BLINK_EN
        for (int i = 0; i < 4; i++) add(5'd2, '0, 18'h00004, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) add(5'd2, '0, 18'h00000, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) add(5'd2, '0, 18'h00004, 1'b0, 1'b0);
        add(5'd2, 18'h00004, 18'h00000, 1'b1, 1'b0);
        add(5'd2, '0, 18'h00000, 1'b0, 1'b0);
        add(5'd20, '0, 18'h00000, 1'b0, 1'b0);
        add(5'd2, '0, 18'h00004, 1'b0, 1'b0);
        add(5'd2, '0, 18'h00004, 1'b0, 1'b0);
`else
        for (int i = 0; i < SHOW; i++) add(5'd16, '0, 18'h10000, 1'b0, 1'b0);
        add(5'd16, '0, 18'h00000, 1'b0, 1'b1);
        add(5'd16, '0, 18'h00000, 1'b0, 1'b0);
        add(5'd3, '0, 18'h00008, 1'b0, 1'b0);
        add(5'd3, 18'h00010, 18'h00008, 1'b0, 1'b0);
        add(5'd3, 18'h00008, 18'h00000, 1'b1, 1'b0);
        add(5'd5, '0, 18'h00020, 1'b0, 1'b0);
        add(5'd5, 18'h00010, 18'h00020, 1'b0, 1'b0);
        add(5'd5, 18'h00020, 18'h00000, 1'b1, 1'b0);
        add(5'd0, '0, 18'h00001, 1'b0, 1'b0);
        add(5'd17, '0, 18'h20000, 1'b0, 1'b0);
        add(5'd20, '0, 18'h00000, 1'b0, 1'b0);
        for (int i = 0; i < SHOW; i++) add(5'd17, '0, 18'h20000, 1'b0, 1'b0);
        add(5'd17, 18'h20000, 18'h00000, 1'b1, 1'b0);
        add(5'd20, '0, 18'h00000, 1'b0, 1'b0);
        add(5'd17, '0, 18'h20000, 1'b0, 1'b0);
`endif
        foreach (vecs[i]) table_step(vecs[i], $sformatf("vec%0d", i));

        // Relatch mid-show must reload the timer: 10 lit cycles after the move, then a miss.
        for (int i = 0; i < 6; i++) step(5'd0, '0, "relatch_pre");
        miss_seen = 0;
        for (int i = 0; i < SHOW; i++) begin
            step(5'd17, '0, "relatch_hold");
            if (miss) miss_seen++;
        end
        check("relatch_no_early_miss", 20'(miss_seen), 20'd0);
        step(5'd17, '0, "relatch_expire");
        check("relatch_reload_miss", {19'd0, miss}, 20'd1);

        // Reset during SHOW clears the LEDs without waiting for a clock edge.
        step(5'd20, '0, "pre_reset_clear");
        step(5'd9, '0, "pre_reset_show");
        check("pre_reset_lit", {2'd0, displayL}, 20'h00200);
        reset = 1'b1;
        #1;
        check("async_reset_clear", {displayL, hit, miss}, 20'd0);
        model_reset();
        @(posedge clk);
        #2;
        check("reset_held", {displayL, hit, miss}, 20'd0);
        reset = 1'b0;
        step(5'd9, '0, "post_reset_reshow");
        check("post_reset_bit9", {2'd0, displayL}, 20'h00200);

        cur_n = 5'd4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) cur_n = 5'($urandom_range(18, 31));
                else cur_n = 5'($urandom_range(0, 17));
            end
            w = '0;
            case ($urandom_range(0, 11))
                0: if (m_active) w[m_hole] = 1'b1;
                1: w[$urandom_range(0, 17)] = 1'b1;
                2: w = 18'($urandom);
                default: w = '0;
            endcase
            step(cur_n, w, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_display.md
Name: mole_display

Overview:
- Single-hole "whack-a-mole" display controller.
- Takes a 5-bit hole index from the game's random or sequence logic and drives an 18-LED red LED bank with a one-hot image of the active mole.
- Times each mole's appearance and detects hits from an 18-bit switch/button bank.
- Sits between the mole-position generator and the board LEDs / score counter.

Parameters:
- NUM_HOLES, 18: number of holes/LEDs. Fixed at 18 for this board; ports are sized for 18.
- SHOW_CYCLES, 50000000: clock cycles a mole stays lit before it counts as a miss (1 s at 50 MHz). Minimum 1.
- BLINK_DIV, 6250000: half-period in cycles of the blink toggle. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- number  in  5  requested mole hole index; 0..17 valid, 18..31 means "no mole".
- whack  in  18  player hit inputs, one per hole, active-high, already synchronised/debounced upstream.
- displayL  out  18  LED image; bit k high means a mole is shown in hole k.
- hit  out  1  one-cycle pulse on a successful whack.
- miss  out  1  one-cycle pulse when a mole times out.

Behaviour:
- Reset (async, active-high), held while reset=1:
  - displayL=0, hit=0, miss=0.
  - state=IDLE, pos=0, timer=0, last=31.
- All outputs are registered. number/whack are sampled on a rising edge; the effect appears on outputs after that edge (1-cycle latency).
- State IDLE (displayL=0):
  - Condition: number<18 and number!=last.
  - Action: pos<=number, last<=number, timer<=SHOW_CYCLES-1, go to SHOW.
  - number>=18: last<=31, so the same index may re-appear later.
  - number==last (same index after a hit/miss): stay IDLE. A mole does not re-pop until number changes.
- State SHOW (displayL = one-hot of pos, i.e. bit pos set, all others 0). Priority, highest first:
  1. whack[pos]=1: hit pulse next cycle, displayL cleared, go to IDLE.
  2. number>=18: displayL cleared, go to IDLE, no hit/miss pulse, last<=31.
  3. number<18 and number!=pos: relatch pos/last, reload timer, stay SHOW. The new one-hot appears next cycle.
  4. timer==0: miss pulse, displayL cleared, go to IDLE.
  5. Otherwise: timer decrements.
- whack bits for holes other than pos are ignored; no penalty.
- A simultaneous whack[pos] and timer expiry counts as a hit.
- hit and miss are never both high. Each is high exactly one cycle per event.
- Reset asserted mid-SHOW clears the LED immediately (asynchronously). After release, the same number re-shows, because last=31.
- Timer width is ceil(log2(SHOW_CYCLES)) bits; no wrap-around (it reloads, never underflows).

Optional Feature:
- Macro: MOLE_BLINK_EN.
- Defined:
  - A free-running prescaler toggles a blink bit every BLINK_DIV cycles. The prescaler is reset to 0 by reset and restarted on every entry to SHOW with blink=1.
  - In SHOW, displayL = one-hot(pos) & {18{blink}}.
  - Timing, hit and miss behaviour are unchanged.
- Not defined: no prescaler logic; displayL is solidly lit in SHOW.

Test Plan:
- Reset then number=16, whack=0 → after 2 edges displayL=18'b01_0000_0000_0000_0000 (bit 16 only); hit=0, miss=0.
- number=16 held, SHOW_CYCLES=10 → displayL bit 16 for 10 cycles, then miss=1 for one cycle and displayL=0. displayL stays 0 while number stays 16; changing to number=3 lights bit 3.
- number=5, assert whack=18'h00020 one cycle → hit=1 next cycle, displayL=0. whack=18'h00010 (wrong hole) instead → no hit, bit 5 stays lit.
- number=0 then number=17 mid-show → displayL moves from 18'h00001 to 18'h20000, timer reloaded. number=20 → displayL=0, no pulses.
- Assert reset during SHOW (number=9) → displayL=0 asynchronously. Release with number=9 → bit 9 relit after 1 edge.
- With MOLE_BLINK_EN, BLINK_DIV=4, number=2 → bit 2 toggles on every 4 cycles; hit via whack[2] still pulses hit.
